selector_arb: RTL and testbench
===============================

Name: selector_arb

Overview:
- Parametrised, registered N-to-1 datapath selector for the CPU datapath.
- Generalises the fixed 2/4/8-input combinational selectors in three ways:
  - width and channel count are parameters;
  - each channel has a valid/ready handshake;
  - an explicit-select or round-robin arbitration mode is available.
- Output passes through a single-entry pipeline register. Used where multiple producers (ALU, multiplier/divider, CP0, memory) share one write-back path.

Parameters:
- WIDTH, 32, data width of each channel and of oZ.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), select/index width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- iC  input  CHANNELS*WIDTH  flattened channel data; channel k is at bits [k*WIDTH +: WIDTH].
- iValid  input  CHANNELS  per-channel data-valid.
- oReady  output  CHANNELS  per-channel accept strobe; at most one bit high (one-hot or zero).
- iMode  input  1  0 = explicit select via iS; 1 = round-robin.
- iS  input  SEL_W  explicit channel index (mode 0 only).
- oZ  output  WIDTH  registered selected data.
- oSel  output  SEL_W  index of the channel held in oZ.
- oValid  output  1  oZ/oSel hold an undelivered word.
- iReady  input  1  downstream accepts oZ this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): oValid=0, oZ=0, oSel=0, round-robin pointer ptr=CHANNELS-1. oReady is 0 during any cycle with rst=1. Reset mid-transfer discards the held word without a handshake.
- load_en = !oValid || iReady (combinational).
- Grant (combinational):
  - Mode 0: grant channel iS if iS<CHANNELS and iValid[iS]=1. iS>=CHANNELS gives no grant; it never aliases to the last channel.
  - Mode 1: grant the first channel with iValid=1, scanning ptr+1, ptr+2, … modulo CHANNELS. No valid channel gives no grant.
- oReady[g] = load_en && grant exists && g is the granted index; all other bits are 0.
- Transfer occurs when oReady[g]=1. At the next edge: oZ←iC[g], oSel←g, oValid←1. In mode 1 only, ptr←g; mode 0 leaves ptr unchanged.
- Drain: if oValid && iReady and no grant exists, then oValid←0 at the edge. oZ and oSel keep their stale values.
- Stall: if oValid && !iReady, oZ, oSel and oValid hold, and all oReady bits are 0.
- Latency: exactly 1 cycle from transfer to oValid.
- Throughput: 1 word/cycle when iReady is held high (back-to-back load while draining).
- iMode and iS are sampled only in cycles where load_en=1. A mode switch takes effect at the next grant; ptr is not reset on mode change.
- Fairness in mode 1: with all channels valid and iReady=1, grant order is 0,1,…,CHANNELS-1,0,…; no channel waits more than CHANNELS-1 grants.
- No combinational path from iReady to oZ. The path iReady→oReady is combinational and intended.

Optional Feature:
- Macro SELECTOR_ARB_STATS_EN.
- When defined:
  - Adds output port oCnt, CHANNELS*16 bits wide, flattened like iC.
  - Holds one 16-bit grant counter per channel, incremented on each transfer from that channel.
  - Counters saturate at 0xFFFF and clear to 0 on rst.
- When undefined: oCnt and the counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles with all iValid=1 -> oValid=0, oZ=0, oSel=0, oReady=0; first mode-1 grant after reset goes to channel 0.
- Mode 0, CHANNELS=4: iS=2, iValid=4'b0100, iC channel 2=0xDEADBEEF, iReady=1 -> oReady=4'b0100 that cycle; next cycle oZ=0xDEADBEEF, oSel=2, oValid=1.
- Mode 0 out-of-range, CHANNELS=5, SEL_W=3: iS=7, all iValid=1 -> oReady=0 and oValid stays 0.
- Round-robin: iMode=1, iValid=4'b1111, iReady=1 for 8 cycles -> oSel sequence 0,1,2,3,0,1,2,3 with oValid=1 continuously after the first cycle.
- Backpressure: load channel 1 (0x12345678), then iReady=0 for 3 cycles with channel 3 valid -> oZ holds 0x12345678, oReady=0 throughout. iReady=1 -> channel 3 granted that cycle; oZ updates next cycle with no gap.
- STATS (SELECTOR_ARB_STATS_EN defined): 70000 back-to-back grants to channel 0 -> channel-0 count = 0xFFFF (saturated), other counts = 0; rst -> all counts 0.

Source files
------------

// File: rtl/selector_arb_if.sv
// Handshake bundle for selector_arb: flattened channel inputs with per-channel valid/ready,
// arbitration controls, and the registered write-back output with its ready.
interface selector_arb_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] iC;
    logic [CHANNELS-1:0]       iValid;
    logic [CHANNELS-1:0]       oReady;
    logic                      iMode;
    logic [SEL_W-1:0]          iS;
    logic [WIDTH-1:0]          oZ;
    logic [SEL_W-1:0]          oSel;
    logic                      oValid;
    logic                      iReady;

    modport master (
        output iC, iValid, iMode, iS, iReady,
        input  oReady, oZ, oSel, oValid
    );

    modport slave (
        input  iC, iValid, iMode, iS, iReady,
        output oReady, oZ, oSel, oValid
    );
endinterface

// File: rtl/selector_arb.sv
// selector_arb: registered N-to-1 write-back selector, explicit-select or round-robin arbitration.
// Define SELECTOR_ARB_STATS_EN to add per-channel saturating 16-bit grant counters on oCnt.
module selector_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst,
    selector_arb_if.slave bus
`ifdef SELECTOR_ARB_STATS_EN
    ,
    output logic [CHANNELS*16-1:0] oCnt
`endif
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    oz_q, oz_d;
    logic [SEL_W-1:0]    osel_q, osel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                ovalid_q, ovalid_d;
    logic [SEL_W-1:0]    grant_idx_s, cand_s;
    logic                grant_vld_s, hit_s, load_en_s, xfer_s;
    logic [CHANNELS-1:0] oready_s;

    // Grant selection; out-of-range iS never aliases onto a real channel.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        if (bus.iMode == 1'b0) begin
            if (int'(bus.iS) < CHANNELS) begin
                grant_vld_s = bus.iValid[bus.iS];
                grant_idx_s = bus.iS;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                cand_s      = SEL_W'((int'(ptr_q) + i) % CHANNELS);
                hit_s       = !grant_vld_s && bus.iValid[cand_s];
                grant_idx_s = hit_s ? cand_s : grant_idx_s;
                grant_vld_s = grant_vld_s | hit_s;
            end
        end
    end

    // Handshake: accept a word whenever the output slot is free or being drained this cycle.
    always_comb begin
        load_en_s = !ovalid_q || bus.iReady;
        xfer_s    = !rst && load_en_s && grant_vld_s;
        oready_s  = '0;
        if (xfer_s) begin
            oready_s[grant_idx_s] = 1'b1;
        end else begin
            oready_s = '0;
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        oz_d     = oz_q;
        osel_d   = osel_q;
        ovalid_d = ovalid_q;
        ptr_d    = ptr_q;
        if (xfer_s) begin
            oz_d     = bus.iC[int'(grant_idx_s)*WIDTH +: WIDTH];
            osel_d   = grant_idx_s;
            ovalid_d = 1'b1;
            ptr_d    = bus.iMode ? grant_idx_s : ptr_q;
        end else if (ovalid_q && bus.iReady) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State registers; reset points ptr at the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            oz_q     <= '0;
            osel_q   <= '0;
            ovalid_q <= 1'b0;
            ptr_q    <= SEL_W'(CHANNELS - 1);
        end else begin
            oz_q     <= oz_d;
            osel_q   <= osel_d;
            ovalid_q <= ovalid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.oZ     = oz_q;
    assign bus.oSel   = osel_q;
    assign bus.oValid = ovalid_q;
    assign bus.oReady = oready_s;

`ifdef SELECTOR_ARB_STATS_EN
    logic [15:0] cnt_q [CHANNELS];
    logic [15:0] cnt_d [CHANNELS];

    // Per-channel grant counters, saturating at all-ones.
    always_comb begin
        oCnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (xfer_s && (grant_idx_s == SEL_W'(k)) && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end else begin
                cnt_d[k] = cnt_q[k];
            end
            oCnt[k*16 +: 16] = cnt_q[k];
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= 16'd0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_selector_arb.sv
// Scoreboard bench for selector_arb: a 4-channel and a 5-channel instance; expected words are
// queued when a grant is expected and compared when the word is delivered downstream.
module tb_selector_arb;
    localparam int W  = 32;
    localparam int C4 = 4;
    localparam int C5 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    selector_arb_if #(.WIDTH(W), .CHANNELS(C4)) bus4 ();
    selector_arb_if #(.WIDTH(W), .CHANNELS(C5)) bus5 ();

`ifdef SELECTOR_ARB_STATS_EN
    logic [C4*16-1:0] cnt4;
    logic [C5*16-1:0] cnt5;
`endif

    selector_arb #(.WIDTH(W), .CHANNELS(C4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
`ifdef SELECTOR_ARB_STATS_EN
        , .oCnt(cnt4)
`endif
    );

    selector_arb #(.WIDTH(W), .CHANNELS(C5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
`ifdef SELECTOR_ARB_STATS_EN
        , .oCnt(cnt5)
`endif
    );

    int          n_err    = 0;
    int          n_checks = 0;
    logic [33:0] sb [$];
    logic [33:0] popped;
    logic        after_rst = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus on the 4-channel instance; dch>=0 forces that channel's data to dval.
    task automatic cycle4(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                          input logic rdy, input int dch, input logic [31:0] dval,
                          input logic [3:0] exp_rdy);
        rst         = r;
        bus4.iMode  = m;
        bus4.iS     = s;
        bus4.iValid = v;
        bus4.iReady = rdy;
        for (int k = 0; k < C4; k++) bus4.iC[k*32 +: 32] = $urandom;
        if (dch >= 0) bus4.iC[dch*32 +: 32] = dval;
        @(negedge clk);
        check_eq("oready", 64'(bus4.oReady), 64'(exp_rdy));
        if (!r) begin
            if (after_rst) begin
                check_eq("rst_oz", 64'(bus4.oZ), 64'd0);
                check_eq("rst_osel", 64'(bus4.oSel), 64'd0);
            end
            check_eq("ovalid", 64'(bus4.oValid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                check_eq("oz", 64'(bus4.oZ), 64'(sb[0][31:0]));
                check_eq("osel", 64'(bus4.oSel), 64'(sb[0][33:32]));
                if (rdy) popped = sb.pop_front();
            end
            for (int k = 0; k < C4; k++) begin
                if (exp_rdy[k]) sb.push_back({2'(k), bus4.iC[k*32 +: 32]});
            end
        end
        after_rst = r;
        @(posedge clk);
        #1;
        if (r) sb.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus5.iMode  = 1'b0;
        bus5.iS     = 3'd0;
        bus5.iValid = 5'b00000;
        bus5.iReady = 1'b1;
        bus5.iC     = '0;

        // Reset with everything valid, then round-robin from channel 0.
        cycle4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, -1, 32'h0, 4'b0000);
        cycle4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, -1, 32'h0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            cycle4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, -1, 32'h0, 4'(4'b0001 << (i % 4)));
        end
        cycle4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, -1, 32'h0, 4'b0000);
        cycle4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, -1, 32'h0, 4'b0000);

        // Explicit select, and a selected channel that is not valid.
        cycle4(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 2, 32'hDEADBEEF, 4'b0100);
        cycle4(1'b0, 1'b0, 2'd1, 4'b0100, 1'b1, -1, 32'h0, 4'b0000);

        // Backpressure: hold channel-1 word for three stalled cycles, then back-to-back.
        cycle4(1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 1, 32'h12345678, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cycle4(1'b0, 1'b0, 2'd3, 4'b1000, 1'b0, 3, 32'hCAFEF00D, 4'b0000);
        end
        cycle4(1'b0, 1'b0, 2'd3, 4'b1000, 1'b1, 3, 32'hCAFEF00D, 4'b1000);

        // Mode-0 grant of channel 2 must not move the round-robin pointer (still 3).
        cycle4(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, -1, 32'h0, 4'b0100);
        cycle4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, -1, 32'h0, 4'b0010);
        cycle4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, -1, 32'h0, 4'b1000);
        cycle4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, -1, 32'h0, 4'b0010);

        // Reset while a word is held: discarded, pointer back to the last channel.
        cycle4(1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 0, 32'h55AA55AA, 4'b0001);
        cycle4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, -1, 32'h0, 4'b0000);
        cycle4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, -1, 32'h0, 4'b0001);
        cycle4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, -1, 32'h0, 4'b0000);
        cycle4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, -1, 32'h0, 4'b0000);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        // Five channels: indices 5..7 are out of range and must never grant.
        bus4.iValid = 4'b0000;
        bus5.iMode  = 1'b0;
        bus5.iValid = 5'b11111;
        bus5.iReady = 1'b1;
        for (int k = 0; k < C5; k++) bus5.iC[k*32 +: 32] = 32'h5000_0000 + 32'(k);
        for (int s = 5; s <= 7; s++) begin
            bus5.iS = 3'(s);
            @(negedge clk);
            check_eq("c5_oor_ready", 64'(bus5.oReady), 64'd0);
            check_eq("c5_oor_valid", 64'(bus5.oValid), 64'd0);
            @(posedge clk);
            #1;
        end
        bus5.iS = 3'd4;
        @(negedge clk);
        check_eq("c5_last_ready", 64'(bus5.oReady), 64'(5'b10000));
        @(posedge clk);
        #1;
        bus5.iMode = 1'b1;
        @(negedge clk);
        check_eq("c5_valid", 64'(bus5.oValid), 64'd1);
        check_eq("c5_oz", 64'(bus5.oZ), 64'h5000_0004);
        check_eq("c5_osel", 64'(bus5.oSel), 64'd4);
        check_eq("c5_rr_ready", 64'(bus5.oReady), 64'(5'b00001));
        @(posedge clk);
        #1;
        bus5.iValid = 5'b00000;
        @(negedge clk);
        check_eq("c5_rr_oz", 64'(bus5.oZ), 64'h5000_0000);
        check_eq("c5_rr_osel", 64'(bus5.oSel), 64'd0);
        @(posedge clk);
        #1;

`ifdef SELECTOR_ARB_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus4.iMode  = 1'b0;
        bus4.iS     = 2'd0;
        bus4.iValid = 4'b0001;
        bus4.iReady = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bus4.iValid = 4'b0000;
        @(negedge clk);
        check_eq("cnt_ch0_sat", 64'(cnt4[15:0]), 64'h0000_0000_0000_FFFF);
        check_eq("cnt_others", 64'(cnt4[63:16]), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("cnt_rst", 64'(cnt4), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
